// File: rtl/inst_fetch_buffer.sv
// Instruction fetch stage: one outstanding word read over req/ack, results
// queued as {pc, instruction} pairs in a small FIFO for the decoder.
module inst_fetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ipc,
    input  logic        redirect,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        dec_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            accept, push, pop;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    // Byte offset of ipc never reaches memory; fetches are word aligned.
    logic unused_ipc_bits;
    assign unused_ipc_bits = ^ipc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY: begin
                if (imem_ack)      state_nxt = IDLE;
                else if (redirect) state_nxt = DRAIN;
            end
            DRAIN:   if (imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stall depends only on state, occupancy and redirect: no ack/ready paths.
    always_comb begin
        accept     = (state == IDLE) && !redirect && (count < FULL);
        pc_stall   = !accept;
        imem_req   = (state != IDLE);
        inst_valid = (count != '0);
        push       = (state == BUSY) && imem_ack && !redirect;
        pop        = inst_valid && dec_ready && !redirect;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      imem_addr <= '0;
        else if (accept) imem_addr <= {ipc[31:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= imem_addr;
            inst_mem[wr_ptr] <= imem_rdata;
        end
    end

    assign inst    = inst_valid ? inst_mem[rd_ptr] : '0;
    assign inst_pc = inst_valid ? pc_mem[rd_ptr]   : '0;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: hand-computed expectations per step.
module tb_inst_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ipc = '0;
    logic        redirect = 1'b0;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        dec_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_fetch_buffer #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ipc        (ipc),
        .redirect   (redirect),
        .pc_stall   (pc_stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .dec_ready  (dec_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present pc, wait for acceptance, hold ack off for lat req cycles, then ack.
    task automatic fetch(input logic [31:0] pc, input int lat, input logic [31:0] data);
        int n;
        ipc = pc;
        #1;
        n = 0;
        while (pc_stall && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        step();
        chk("f_req", imem_req, 1);
        chk("f_addr", imem_addr, {pc[31:2], 2'b00});
        for (int i = 0; i < lat; i++) begin
            step();
            chk("f_stall_busy", pc_stall, 1);
            chk("f_req_held", imem_req, 1);
        end
        imem_ack = 1'b1;
        imem_rdata = data;
        step();
        imem_ack = 1'b0;
    endtask

    task automatic flush();
        redirect = 1'b1;
        #1;
        chk("redir_stall", pc_stall, 1);
        step();
        redirect = 1'b0;
        #1;
        chk("flush_valid", inst_valid, 0);
        chk("flush_inst", inst, 0);
        chk("flush_pc", inst_pc, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step();
        step();
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_stall", pc_stall, 0);

        // basic fetch, ack in the first request cycle
        rst_n = 1'b1;
        dec_ready = 1'b1;
        fetch(32'h0000_0040, 0, 32'hAAAA_0001);
        chk("t1_valid", inst_valid, 1);
        chk("t1_pc", inst_pc, 32'h40);
        chk("t1_inst", inst, 32'hAAAA_0001);
        chk("t1_stall", pc_stall, 0);

        // unaligned ipc is word aligned
        fetch(32'h0000_0103, 0, 32'hBBBB_0002);
        chk("t2_valid", inst_valid, 1);
        chk("t2_pc", inst_pc, 32'h100);
        chk("t2_inst", inst, 32'hBBBB_0002);
        flush();

        // latency 3, decoder stalled: fill FIFO
        dec_ready = 1'b0;
        fetch(32'h0000_0040, 3, 32'hCCCC_0003);
        chk("t3_pc0", inst_pc, 32'h40);
        fetch(32'h0000_0044, 3, 32'hCCCC_0004);
        chk("t3_full_stall", pc_stall, 1);
        chk("t3_head", inst_pc, 32'h40);
        step();
        step();
        chk("t3_full_stall2", pc_stall, 1);
        chk("t3_noreq", imem_req, 0);
        ipc = 32'h0000_0048;
        dec_ready = 1'b1;
        #1;
        chk("t3_ready_nopath", pc_stall, 1);
        step();
        chk("t3_pop1_pc", inst_pc, 32'h44);
        chk("t3_pop1_inst", inst, 32'hCCCC_0004);
        chk("t3_unstall", pc_stall, 0);
        step();
        chk("t3_empty", inst_valid, 0);
        chk("t3_resume_req", imem_req, 1);
        chk("t3_resume_addr", imem_addr, 32'h48);
        imem_ack = 1'b1;
        imem_rdata = 32'hCCCC_0005;
        step();
        imem_ack = 1'b0;
        chk("t3_new_pc", inst_pc, 32'h48);
        chk("t3_new_inst", inst, 32'hCCCC_0005);

        // redirect mid-request: drain and drop
        dec_ready = 1'b0;
        flush();
        ipc = 32'h0000_0080;
        step();
        chk("t4_req", imem_req, 1);
        step();
        redirect = 1'b1;
        ipc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        #1;
        chk("t4_drain_req", imem_req, 1);
        chk("t4_drain_addr", imem_addr, 32'h80);
        chk("t4_drain_stall", pc_stall, 1);
        chk("t4_drain_valid", inst_valid, 0);
        step();
        chk("t4_drain_req2", imem_req, 1);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("t4_dropped", inst_valid, 0);
        chk("t4_idle_req", imem_req, 0);
        chk("t4_idle_stall", pc_stall, 0);
        step();
        chk("t4_new_addr", imem_addr, 32'h200);
        chk("t4_new_req", imem_req, 1);
        imem_ack = 1'b1;
        imem_rdata = 32'hEEEE_0006;
        step();
        imem_ack = 1'b0;
        chk("t4_pc", inst_pc, 32'h200);
        chk("t4_inst", inst, 32'hEEEE_0006);

        // redirect together with ack and pop, count=1
        ipc = 32'h0000_0300;
        step();
        chk("t5_addr", imem_addr, 32'h300);
        chk("t5_valid_before", inst_valid, 1);
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_0007;
        dec_ready = 1'b1;
        redirect = 1'b1;
        step();
        imem_ack = 1'b0;
        redirect = 1'b0;
        dec_ready = 1'b0;
        #1;
        chk("t5_valid", inst_valid, 0);
        chk("t5_idle_req", imem_req, 0);
        chk("t5_stall", pc_stall, 0);

        // async reset mid-request with one queued entry
        step();
        chk("t6_req", imem_req, 1);
        imem_ack = 1'b1;
        imem_rdata = 32'h1111_0008;
        step();
        imem_ack = 1'b0;
        ipc = 32'h0000_0304;
        step();
        chk("t6_busy_req", imem_req, 1);
        chk("t6_queued", inst_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", inst_valid, 0);
        chk("t6_rst_inst", inst, 0);
        chk("t6_rst_pc", inst_pc, 0);
        chk("t6_rst_req", imem_req, 0);
        chk("t6_rst_addr", imem_addr, 0);
        chk("t6_rst_stall", pc_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_0009;
        step();
        imem_ack = 1'b0;
        chk("t6_late_ack", inst_valid, 0);
        chk("t6_new_req", imem_req, 1);
        chk("t6_new_addr", imem_addr, 32'h304);
        imem_ack = 1'b1;
        imem_rdata = 32'h2222_000A;
        step();
        imem_ack = 1'b0;
        chk("t6_pc", inst_pc, 32'h304);
        chk("t6_inst", inst, 32'h2222_000A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
